// File: rtl/bcd_chain_counter.sv
// Cascaded BCD digit counter with per-digit modulus, up/down stepping,
// validated parallel load and an optional whole-chain wrap value (TOP).
module bcd_chain_counter #(
  parameter int                  DIGITS  = 6,
  parameter logic [4*DIGITS-1:0] MODULI  = 24'h3A6A6A,
  parameter bit                  WRAP_EN = 1'b1,
  parameter logic [4*DIGITS-1:0] TOP     = 24'h235959
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tc,
  output logic                  load_err
);

  // Configuration errors stop elaboration; they have no run-time behaviour.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cfg_chk
    if (MODULI[4*gi +: 4] < 4'd2 || MODULI[4*gi +: 4] > 4'd10) begin : g_bad_mod
      $error("bcd_chain_counter: digit %0d modulus outside 2..10", gi);
    end
    if (WRAP_EN && (TOP[4*gi +: 4] >= MODULI[4*gi +: 4])) begin : g_bad_top
      $error("bcd_chain_counter: digit %0d of TOP not below its modulus", gi);
    end
  end

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_load_err;

  logic [DIGITS:0]     w_carry;
  logic [DIGITS:0]     w_borrow;
  logic [4*DIGITS-1:0] w_step;
  logic [4*DIGITS-1:0] w_next;
  logic                w_digits_ok;
  logic                w_load_ok;
  logic                w_at_top;
  logic                w_up_bound;
  logic                w_dn_bound;

  // w_carry[i]/w_borrow[i]: every digit below i sits at its wrap point, so digit i steps.
  always_comb begin
    w_carry     = '0;
    w_borrow    = '0;
    w_step      = r_bcd;
    w_digits_ok = 1'b1;
    w_carry[0]  = 1'b1;
    w_borrow[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (up) begin
        if (w_carry[i]) begin
          w_step[4*i +: 4] = (r_bcd[4*i +: 4] == MODULI[4*i +: 4] - 4'd1) ?
                             4'd0 : r_bcd[4*i +: 4] + 4'd1;
        end
      end else begin
        if (w_borrow[i]) begin
          w_step[4*i +: 4] = (r_bcd[4*i +: 4] == 4'd0) ?
                             MODULI[4*i +: 4] - 4'd1 : r_bcd[4*i +: 4] - 4'd1;
        end
      end
      w_carry[i+1]  = w_carry[i] && (r_bcd[4*i +: 4] == MODULI[4*i +: 4] - 4'd1);
      w_borrow[i+1] = w_borrow[i] && (r_bcd[4*i +: 4] == 4'd0);
      if (load_value[4*i +: 4] >= MODULI[4*i +: 4]) begin
        w_digits_ok = 1'b0;
      end
    end
  end

  assign w_at_top   = (r_bcd == TOP);
  assign w_up_bound = WRAP_EN ? w_at_top : w_carry[DIGITS];
  assign w_dn_bound = w_borrow[DIGITS];

  // With all digits legal, a plain unsigned compare orders BCD values correctly.
  assign w_load_ok  = w_digits_ok && (!WRAP_EN || (load_value <= TOP));

  assign w_next = (up  && WRAP_EN && w_at_top)   ? '0  :
                  (!up && WRAP_EN && w_dn_bound) ? TOP : w_step;

  assign tc = reset_n & en & ~load & (up ? w_up_bound : w_dn_bound);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_bcd      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) begin
          r_bcd <= load_value;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (en) begin
        r_bcd <= w_next;
      end
    end
  end

  assign bcd      = r_bcd;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: a time-of-day instance (default parameters) and a
// two-digit natural-wrap instance share control inputs; a mixed-radix model predicts both.
module tb_bcd_chain_counter;

  localparam int W = 26;  // {tc, bcd[23:0], load_err}

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        en      = 1'b0;
  logic        up      = 1'b0;
  logic        load    = 1'b0;
  logic [23:0] lv6     = '0;
  logic [7:0]  lv2     = '0;
  logic [23:0] bcd6;
  logic [7:0]  bcd2;
  logic        tc6, tc2, err6, err2;

  logic [W-1:0] exp6_q[$];
  logic [W-1:0] exp2_q[$];
  logic [23:0]  m6_bcd = '0;
  logic [23:0]  m2_bcd = '0;

  int n_vec = 0;
  int n_err = 0;

  bcd_chain_counter u_tod (
    .clock(clock), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_value(lv6), .bcd(bcd6), .tc(tc6), .load_err(err6)
  );

  bcd_chain_counter #(
    .DIGITS(2), .MODULI(8'hAA), .WRAP_EN(1'b0), .TOP(8'h99)
  ) u_nat (
    .clock(clock), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_value(lv2), .bcd(bcd2), .tc(tc2), .load_err(err2)
  );

  always #5 clock = ~clock;

  // ---------------- reference model: values as mixed-radix integers ----------------
  function automatic int to_idx(input logic [23:0] v, input int nd, input logic [23:0] mods);
    int idx = 0;
    for (int i = nd - 1; i >= 0; i--) idx = idx * int'(mods[4*i +: 4]) + int'(v[4*i +: 4]);
    return idx;
  endfunction

  function automatic logic [23:0] from_idx(input int idx, input int nd, input logic [23:0] mods);
    logic [23:0] v = '0;
    int rem = idx;
    for (int i = 0; i < nd; i++) begin
      v[4*i +: 4] = 4'(rem % int'(mods[4*i +: 4]));
      rem = rem / int'(mods[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] model(
      input logic [23:0] cur, input int nd, input logic [23:0] mods, input bit wrap,
      input logic [23:0] top, input logic rn, input logic e, input logic u,
      input logic l, input logic [23:0] lv);
    int total = 1;
    int max_idx, ci, li;
    bit ok = 1'b1;
    logic t;
    logic [23:0] nxt;
    logic err = 1'b0;
    for (int i = 0; i < nd; i++) begin
      total = total * int'(mods[4*i +: 4]);
      if (lv[4*i +: 4] >= mods[4*i +: 4]) ok = 1'b0;
    end
    max_idx = wrap ? to_idx(top, nd, mods) : total - 1;
    ci = to_idx(cur, nd, mods);
    li = to_idx(lv, nd, mods);
    t = rn && e && !l && (u ? (ci == max_idx) : (ci == 0));
    nxt = cur;
    if (!rn) begin
      nxt = '0;
    end else if (l) begin
      if (ok && li <= max_idx) nxt = lv;
      else err = 1'b1;
    end else if (e) begin
      if (u) nxt = from_idx((ci == max_idx) ? 0 : ci + 1, nd, mods);
      else   nxt = from_idx((ci == 0) ? max_idx : ci - 1, nd, mods);
    end
    return {t, nxt, err};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rn, input logic e, input logic u, input logic l,
                      input logic [23:0] v6, input logic [7:0] v2);
    logic [W-1:0] r6, r2;
    @(posedge clock);
    #2;
    reset_n = rn; en = e; up = u; load = l; lv6 = v6; lv2 = v2;
    r6 = model(m6_bcd, 6, 24'h3A6A6A, 1'b1, 24'h235959, rn, e, u, l, v6);
    r2 = model(m2_bcd, 2, 24'h0000AA, 1'b0, 24'h000099, rn, e, u, l, {16'h0, v2});
    exp6_q.push_back(r6);
    exp2_q.push_back(r2);
    m6_bcd = r6[24:1];
    m2_bcd = r2[24:1];
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] e6, e2;
    forever begin
      @(negedge clock);
      if (exp6_q.size() != 0) check("tc6", {23'h0, tc6}, {23'h0, exp6_q[0][25]});
      if (exp2_q.size() != 0) check("tc2", {23'h0, tc2}, {23'h0, exp2_q[0][25]});
      @(posedge clock);
      #1;
      if (exp6_q.size() != 0) begin
        e6 = exp6_q.pop_front();
        check("bcd6", bcd6, e6[24:1]);
        check("err6", {23'h0, err6}, {23'h0, e6[0]});
      end
      if (exp2_q.size() != 0) begin
        e2 = exp2_q.pop_front();
        check("bcd2", {16'h0, bcd2}, e2[24:1]);
        check("err2", {23'h0, err2}, {23'h0, e2[0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] r6;
    logic [7:0]  r2;
    // reset held with every request active
    step(0, 1, 1, 1, 24'h123456, 8'h12);
    step(0, 1, 1, 1, 24'h123456, 8'h12);
    step(1, 1, 1, 0, 24'h0, 8'h0);
    // up wrap at TOP / natural wrap from 98, then reverse
    step(1, 0, 1, 1, 24'h235958, 8'h98);
    step(1, 1, 1, 0, 24'h0, 8'h0);
    step(1, 1, 1, 0, 24'h0, 8'h0);
    step(1, 1, 0, 0, 24'h0, 8'h0);
    step(1, 1, 1, 0, 24'h0, 8'h0);
    step(1, 0, 1, 0, 24'h0, 8'h0);
    // down wrap from 000001
    step(1, 0, 0, 1, 24'h000001, 8'h01);
    step(1, 1, 0, 0, 24'h0, 8'h0);
    step(1, 1, 0, 0, 24'h0, 8'h0);
    step(1, 1, 0, 0, 24'h0, 8'h0);
    // load validation: bad digit, above TOP, then good
    step(1, 0, 1, 1, 24'h006000, 8'hA0);
    step(1, 0, 1, 0, 24'h0, 8'h0);
    step(1, 0, 1, 1, 24'h240000, 8'h24);
    step(1, 0, 1, 0, 24'h0, 8'h0);
    step(1, 0, 1, 1, 24'h120000, 8'h12);
    step(1, 0, 1, 0, 24'h0, 8'h0);
    // load beats en in the same cycle
    step(1, 1, 1, 1, 24'h120000, 8'h50);
    step(1, 0, 1, 0, 24'h0, 8'h0);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        r6 = from_idx($urandom_range(0, 86399), 6, 24'h3A6A6A);
        r2 = 8'(from_idx($urandom_range(0, 99), 2, 24'h0000AA));
      end else begin
        r6 = 24'($urandom);
        r2 = 8'($urandom);
      end
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), r6, r2);
    end
    step(1, 0, 1, 0, 24'h0, 8'h0);
    repeat (3) @(posedge clock);
    #3;
    if (exp6_q.size() != 0 || exp2_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", exp6_q.size(), exp2_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised, synchronously reset chain of cascaded BCD digits with a per-digit modulus, up/down counting, parallel load with validation, and an optional whole-chain wrap value. It replaces the hand-built, fixed-modulus digit counters in the clock datapath. One instance covers a full HH:MM:SS time-of-day register (23:59:59 → 00:00:00). A terminal-count output allows further cascading, e.g. to a day counter.

## Interface
- DIGITS, 6: number of BCD digits; digit 0 is least significant and occupies bits [3:0].
- MODULI, 24'h3A6A6A: packed 4 bits per digit, digit 0 in LSBs.
  - Per-digit count modulus, legal range 2..10 (4'hA = 10).
  - Default gives seconds, tens-of-seconds, minutes, tens-of-minutes, hours, tens-of-hours = 10, 6, 10, 6, 10, 3.
- WRAP_EN, 1: 1 = the chain wraps at TOP; 0 = natural wrap when every digit is at modulus−1.
- TOP, 24'h235959: BCD value of the inclusive chain maximum, used only when WRAP_EN=1. Every digit of TOP must be below its modulus.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  count tick (one step per cycle while high).
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel-load request.
- load_value  in  4*DIGITS  BCD value to load.
- bcd  out  4*DIGITS  registered counter value.
- tc  out  1  combinational terminal count: this cycle's step wraps the chain.
- load_err  out  1  registered one-cycle pulse: the last load was rejected.

## Operation
- Priority at each rising edge: reset_n low > load > en. With none active, bcd holds.
- Reset (reset_n=0 at an edge):
  - bcd = 0 and load_err = 0.
  - tc is forced to 0 while reset_n is low.
  - en and load are ignored in that cycle.
- Load:
  - A load is valid only if every digit of load_value is below its modulus. With WRAP_EN=1, load_value must also be ≤ TOP, compared as a BCD number.
  - Valid load: bcd = load_value and load_err = 0.
  - Invalid load: bcd holds and load_err = 1 for exactly the next cycle.
  - A load suppresses en in the same cycle, so no count step occurs.
- Up step (en=1, up=1, no load):
  - Digit i increments iff all lower digits are at their own modulus−1. Digit 0 always steps.
  - A digit at modulus−1 that steps goes to 0.
  - WRAP_EN=1 and bcd==TOP: the whole chain goes to 0, overriding per-digit arithmetic.
- Down step (en=1, up=0, no load):
  - Digit i decrements iff all lower digits are 0.
  - A digit at 0 that steps goes to modulus−1.
  - WRAP_EN=1 and bcd==0: the chain goes to TOP.
  - WRAP_EN=0 and bcd==0: every digit goes to modulus−1.
- Terminal count: tc = reset_n & en & !load & boundary.
  - Up boundary: bcd==TOP when WRAP_EN=1, otherwise all digits at modulus−1.
  - Down boundary: bcd==0.
- Direction may change on any cycle. The step is always computed from the current bcd and the current up.
- bcd never holds a non-BCD digit or a value above TOP. Only reset, valid loads and legal steps change it.
- Out-of-range parameters (a modulus outside 2..10, an illegal TOP) are a configuration error. They are flagged by an elaboration-time check and have no run-time behaviour.

## Timing
- bcd and load_err are registered and change only on rising edges of clock.
- Count latency is one cycle: en sampled high at edge k gives the new value after edge k.
- Load latency is one cycle. load_err goes high after the same edge that rejected the load and low after the next edge unless another invalid load occurs.
- tc is combinational from en, load, reset_n, up and bcd. It is valid in the cycle before the wrapping edge and is intended to drive the en of a downstream counter on the same clock.
- Back-to-back en gives one step per cycle with no dead cycles, including across wraps.
- Reset mid-count or mid-load takes effect at that edge. bcd = 0 after it, and any pending load is discarded.

## Test plan
- Reset:
  - Stimulus: reset_n=0 for 2 cycles with en=1, load=1, load_value=24'h123456.
  - Required: bcd=000000, load_err=0 and tc=0 throughout. After release with en=1, up=1: bcd=000001 after one edge.
- Up wrap (default parameters):
  - Stimulus: load 235958, then en=1, up=1 for 3 cycles.
  - Required: bcd goes 235959 → 000000 → 000001. tc=1 only in the cycle where bcd=235959.
- Down wrap:
  - Stimulus: load 000001, then en=1, up=0 for 3 cycles.
  - Required: bcd goes 000000 → 235959 → 235958. tc=1 only while bcd=000000.
- Load validation:
  - Stimulus: load 006000 (tens-of-minutes digit 6 ≥ modulus 6), then load 240000 (> TOP).
  - Required: bcd unchanged after each, with a one-cycle load_err=1 after each. A following load of 120000 gives bcd=120000 and load_err=0.
- Priority:
  - Stimulus: load=1, load_value=120000, en=1, up=1 in the same cycle.
  - Required: bcd=120000, not 120001, and tc=0.
- Natural wrap (DIGITS=2, MODULI=8'hAA, WRAP_EN=0):
  - Stimulus: from 98, en=1, up=1 for 2 cycles, then up=0 for 1 cycle.
  - Required: bcd goes 99 → 00 → 99, with tc=1 while at 99 going up and while at 00 going down.
